// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the simple master's FSM state type.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10
  } state_e;

endpackage

// File: rtl/ahb_simple_master.sv
// Single-transfer AHB-Lite master: one local command becomes one SINGLE word
// transfer, with a one-cycle response pulse and a saturating error counter.
module ahb_simple_master
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  CmdValid,
  output logic                  CmdReady,
  input  logic                  CmdWrite,
  input  logic [ADDR_WIDTH-1:0] CmdAddr,
  input  logic [DATA_WIDTH-1:0] CmdWData,
  output logic                  RspValid,
  output logic [DATA_WIDTH-1:0] RspRData,
  output logic                  RspError,
  output logic [7:0]            ErrCount,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  input  logic                  HRESP,
  input  logic [DATA_WIDTH-1:0] HRDATA
);

  state_e                  state_q;
  htrans_e                 htrans_q;
  logic                    ready_q;
  logic [ADDR_WIDTH-1:0]   haddr_q;
  logic                    hwrite_q;
  logic [DATA_WIDTH-1:0]   hwdata_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    rsp_valid_q;
  logic                    rsp_err_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;
  logic [7:0]              err_cnt_q;
  logic [7:0]              err_cnt_d;

  always_comb begin
    err_cnt_d = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + 8'd1;
  end

  // The first beat of a two-cycle ERROR has HREADY=0, so it is simply a DATA wait state.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q     <= ST_IDLE;
      htrans_q    <= HTRANS_IDLE;
      ready_q     <= 1'b1;
      haddr_q     <= '0;
      hwrite_q    <= 1'b0;
      hwdata_q    <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (CmdValid) begin
            state_q  <= ST_ADDR;
            ready_q  <= 1'b0;
            htrans_q <= HTRANS_NONSEQ;
            haddr_q  <= CmdAddr;
            hwrite_q <= CmdWrite;
            wdata_q  <= CmdWData;
          end
        end
        ST_ADDR: begin
          if (HREADY) begin
            state_q  <= ST_DATA;
            htrans_q <= HTRANS_IDLE;
            hwdata_q <= wdata_q;
          end
        end
        ST_DATA: begin
          if (HREADY) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= HRESP;
            if (!hwrite_q) rsp_rdata_q <= HRDATA;
            if (HRESP == HRESP_ERROR) err_cnt_q <= err_cnt_d;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          ready_q  <= 1'b1;
          htrans_q <= HTRANS_IDLE;
        end
      endcase
    end
  end

  assign CmdReady = ready_q;
  assign RspValid = rsp_valid_q;
  assign RspRData = rsp_rdata_q;
  assign RspError = rsp_err_q;
  assign ErrCount = err_cnt_q;
  assign HADDR    = haddr_q;
  assign HTRANS   = htrans_q;
  assign HWRITE   = hwrite_q;
  assign HSIZE    = HSIZE_WORD;
  assign HBURST   = HBURST_SINGLE;
  assign HWDATA   = hwdata_q;

endmodule

// File: tb/tb_ahb_simple_master.sv
// Bench for ahb_simple_master: transaction-level reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_ahb_simple_master;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          HCLK = 1'b0;
  logic          HRESET = 1'b1;
  logic          CmdValid = 1'b0;
  logic          CmdWrite = 1'b0;
  logic [AW-1:0] CmdAddr = '0;
  logic [DW-1:0] CmdWData = '0;
  logic          HREADY = 1'b1;
  logic          HRESP = 1'b0;
  logic [DW-1:0] HRDATA = '0;
  logic          CmdReady, RspValid, RspError, HWRITE;
  logic [DW-1:0] RspRData, HWDATA;
  logic [7:0]    ErrCount;
  logic [AW-1:0] HADDR;
  logic [1:0]    HTRANS;
  logic [2:0]    HSIZE, HBURST;

  always #5 HCLK = ~HCLK;

  ahb_simple_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .CmdValid(CmdValid), .CmdReady(CmdReady),
    .CmdWrite(CmdWrite), .CmdAddr(CmdAddr), .CmdWData(CmdWData),
    .RspValid(RspValid), .RspRData(RspRData), .RspError(RspError),
    .ErrCount(ErrCount), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HREADY(HREADY),
    .HRESP(HRESP), .HRDATA(HRDATA)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a transfer is outstanding from acceptance until its second
  // HREADY-high edge; the first such edge ends the address phase.
  bit          m_busy = 0;
  int          m_ready_edges = 0;
  logic [31:0] m_haddr = '0, m_hwdata = '0, m_cap = '0, m_rdata = '0;
  bit          m_hwrite = 0, m_rv = 0, m_re = 0;
  int          m_errcnt = 0;
  int          pos_cnt = 0, m_acc = 0, m_waits = 0;

  always @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      m_busy = 0; m_ready_edges = 0;
      m_haddr = '0; m_hwdata = '0; m_cap = '0; m_rdata = '0;
      m_hwrite = 0; m_rv = 0; m_re = 0; m_errcnt = 0;
    end else begin
      pos_cnt++;
      m_rv = 0;
      if (!m_busy) begin
        if (CmdValid) begin
          m_busy = 1; m_ready_edges = 0; m_acc = pos_cnt; m_waits = 0;
          m_haddr = CmdAddr; m_hwrite = CmdWrite; m_cap = CmdWData;
        end
      end else if (!HREADY) begin
        m_waits++;
      end else if (m_ready_edges == 0) begin
        m_ready_edges = 1;
        m_hwdata = m_cap;
      end else begin
        m_busy = 0; m_rv = 1; m_re = HRESP;
        if (!m_hwrite) m_rdata = HRDATA;
        if (HRESP && m_errcnt < 255) m_errcnt++;
      end
    end
  end

  always @(negedge HCLK) begin
    chk("CmdReady", CmdReady, !m_busy);
    chk("HTRANS", HTRANS, (m_busy && m_ready_edges == 0) ? 2'b10 : 2'b00);
    chk("HADDR", HADDR, m_haddr);
    chk("HWRITE", HWRITE, m_hwrite);
    chk("HWDATA", HWDATA, m_hwdata);
    chk("HSIZE", HSIZE, 3'b010);
    chk("HBURST", HBURST, 3'b000);
    chk("RspValid", RspValid, m_rv);
    chk("RspError", RspError, m_re);
    chk("RspRData", RspRData, m_rdata);
    chk("ErrCount", ErrCount, m_errcnt);
    if (!HRESET && RspValid === 1'b1)
      chk("latency", pos_cnt - m_acc + 1, 3 + m_waits);
  end

  // Drives inputs just after a falling edge; they are sampled on the next rising edge.
  task automatic cyc(input bit v, input bit w, input logic [31:0] a, input logic [31:0] wd,
                     input bit rdy, input bit rsp, input logic [31:0] rd);
    @(negedge HCLK);
    #1;
    CmdValid = v; CmdWrite = w; CmdAddr = a; CmdWData = wd;
    HREADY = rdy; HRESP = rsp; HRDATA = rd;
  endtask

  task automatic idle(input bit rdy, input bit rsp);
    cyc(0, 0, $urandom, $urandom, rdy, rsp, $urandom);
  endtask

  task automatic err_xfer(input logic [31:0] a);
    cyc(1, 0, a, '0, 1, 0, $urandom);
    idle(1, 0);
    idle(0, 1);
    idle(1, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int es;
    bit rdy, rsp;
    repeat (3) idle(1, 0);
    HRESET = 1'b0;
    idle(1, 0);
    chk("rst_ready", CmdReady, 1'b1);
    chk("rst_htrans", HTRANS, 2'b00);
    chk("rst_errcnt", ErrCount, 8'h00);
    chk("rst_rspvalid", RspValid, 1'b0);

    // Zero-wait write
    cyc(1, 1, 32'h0000_1000, 32'hDEAD_BEEF, 1, 0, $urandom);
    idle(1, 0);
    chk("wr_nonseq", HTRANS, 2'b10);
    chk("wr_hwrite", HWRITE, 1'b1);
    chk("wr_haddr", HADDR, 32'h0000_1000);
    idle(1, 0);
    chk("wr_idle_data", HTRANS, 2'b00);
    chk("wr_hwdata", HWDATA, 32'hDEAD_BEEF);
    idle(1, 0);
    chk("wr_rspvalid", RspValid, 1'b1);
    chk("wr_rsperr", RspError, 1'b0);
    idle(1, 0);
    chk("wr_pulse_end", RspValid, 1'b0);

    // Read with two data wait states
    cyc(1, 0, 32'h0000_2004, '0, 1, 0, $urandom);
    idle(1, 0);
    idle(0, 0);
    idle(0, 0);
    chk("rd_no_early_rsp", RspValid, 1'b0);
    cyc(0, 0, '0, '0, 1, 0, 32'h1234_5678);
    idle(1, 0);
    chk("rd_rspvalid", RspValid, 1'b1);
    chk("rd_rdata", RspRData, 32'h1234_5678);

    // Two-cycle ERROR on a read
    cyc(1, 0, 32'h0000_BAD0, '0, 1, 0, $urandom);
    idle(1, 0);
    idle(0, 1);
    chk("err_htrans1", HTRANS, 2'b00);
    idle(1, 1);
    chk("err_htrans2", HTRANS, 2'b00);
    idle(1, 0);
    chk("err_rspvalid", RspValid, 1'b1);
    chk("err_rsperr", RspError, 1'b1);
    chk("err_count1", ErrCount, 8'h01);

    // Address phase stretched by three wait states
    cyc(1, 1, 32'h0000_0C00, 32'h0BAD_CAFE, 0, 0, $urandom);
    for (int i = 0; i < 4; i++) begin
      idle((i == 3), 0);
      chk("aw_htrans", HTRANS, 2'b10);
      chk("aw_haddr", HADDR, 32'h0000_0C00);
      chk("aw_ready", CmdReady, 1'b0);
    end
    idle(1, 0);
    chk("aw_data", HTRANS, 2'b00);
    idle(1, 0);
    chk("aw_rsp", RspValid, 1'b1);

    // Reset during the data phase of a write
    cyc(1, 1, 32'h0000_3000, 32'hCAFE_F00D, 1, 0, $urandom);
    idle(1, 0);
    idle(0, 0);
    chk("rm_hwdata", HWDATA, 32'hCAFE_F00D);
    HRESET = 1'b1;
    #1;
    chk("rm_haddr", HADDR, 32'h0);
    chk("rm_hwdata0", HWDATA, 32'h0);
    chk("rm_hwrite", HWRITE, 1'b0);
    chk("rm_htrans", HTRANS, 2'b00);
    chk("rm_rspvalid", RspValid, 1'b0);
    chk("rm_errcnt", ErrCount, 8'h00);
    idle(1, 0);
    idle(1, 0);
    HRESET = 1'b0;
    cyc(1, 0, 32'h0000_0040, '0, 1, 0, $urandom);
    idle(1, 0);
    cyc(0, 0, '0, '0, 1, 0, 32'h5555_AAAA);
    idle(1, 0);
    chk("rm_new_rsp", RspValid, 1'b1);
    chk("rm_new_rdata", RspRData, 32'h5555_AAAA);

    // Randomized traffic; the slave follows the reference model's phase
    es = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge HCLK);
      #1;
      if (m_busy && m_ready_edges == 1) begin
        if (es == 1) begin
          rdy = 1; rsp = 1; es = 0;
        end else if ($urandom_range(0, 4) == 0) begin
          rdy = 0; rsp = 1; es = 1;
        end else begin
          rdy = ($urandom_range(0, 3) != 0); rsp = 0;
        end
      end else begin
        rdy = ($urandom_range(0, 3) != 0); rsp = 0;
      end
      CmdValid = ($urandom_range(0, 1) == 1);
      CmdWrite = ($urandom_range(0, 1) == 1);
      CmdAddr  = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      CmdWData = $urandom;
      HREADY = rdy; HRESP = rsp; HRDATA = $urandom;
    end

    // Error counter saturation over 257 error completions from zero
    idle(1, 0);
    HRESET = 1'b1;
    idle(1, 0);
    HRESET = 1'b0;
    for (int i = 0; i < 254; i++) err_xfer(32'hFFFF_0000);
    idle(1, 0);
    chk("sat_254", ErrCount, 8'hFE);
    err_xfer(32'hFFFF_0000);
    idle(1, 0);
    chk("sat_255", ErrCount, 8'hFF);
    err_xfer(32'hFFFF_0004);
    err_xfer(32'hFFFF_0008);
    idle(1, 0);
    chk("sat_257", ErrCount, 8'hFF);
    idle(1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahb_simple_master.md
AHB_SIMPLE_MASTER -- requirements
Module: ahb_simple_master

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, sets the HADDR and CmdAddr width.
REQ-002 Parameter DATA_WIDTH, default 32, sets the HWDATA, HRDATA, CmdWData and RspRData width.
REQ-003 HCLK  in  1  system bus clock; all state changes on its rising edge.
REQ-004 HRESET  in  1  asynchronous, active-high reset.
REQ-005 CmdValid  in  1  local command request.
REQ-006 CmdReady  out  1  block can accept a command this cycle.
REQ-007 CmdWrite  in  1  1 = write, 0 = read.
REQ-008 CmdAddr  in  ADDR_WIDTH  transfer address, word-aligned.
REQ-009 CmdWData  in  DATA_WIDTH  write data.
REQ-010 RspValid  out  1  one-cycle pulse when a transfer completes.
REQ-011 RspRData  out  DATA_WIDTH  read data, valid with RspValid for reads.
REQ-012 RspError  out  1  transfer ended with an ERROR response, valid with RspValid.
REQ-013 ErrCount  out  8  saturating count of ERROR responses.
REQ-014 HADDR  out  ADDR_WIDTH, HTRANS  out  2, HWRITE  out  1, HSIZE  out  3, HBURST  out  3, HWDATA  out  DATA_WIDTH  AHB master outputs.
REQ-015 HREADY  in  1, HRESP  in  1, HRDATA  in  DATA_WIDTH  AHB slave-to-master returns.

Function
REQ-016 The block SHALL be a registered FSM with states IDLE, ADDR and DATA.
REQ-017 CmdReady SHALL be 1 only in IDLE; a command is accepted on any edge where CmdValid=1 and CmdReady=1.
REQ-018 On acceptance the FSM SHALL enter ADDR, register HADDR=CmdAddr, HWRITE=CmdWrite and HTRANS=NONSEQ (2'b10), and capture CmdWData internally.
REQ-019 HSIZE SHALL be constant 3'b010 (word); HBURST SHALL be constant 3'b000 (SINGLE).
REQ-020 In ADDR, the FSM SHALL hold all address-phase outputs while HREADY=0, then move to DATA on the first edge with HREADY=1.
REQ-021 On the ADDR->DATA edge, HTRANS SHALL become IDLE (2'b00) and HWDATA SHALL take the captured write data, which is held stable throughout DATA.
REQ-022 In DATA, HREADY=0 SHALL extend the phase with no other state change.
REQ-023 In DATA, an edge with HREADY=1 SHALL:
  - return the FSM to IDLE;
  - pulse RspValid for exactly the next cycle;
  - register RspError=HRESP;
  - register RspRData=HRDATA for reads, or hold its previous value for writes.
REQ-024 Two-cycle ERROR (HRESP=1,HREADY=0 then HRESP=1,HREADY=1): the first cycle SHALL be treated as a wait state, with HTRANS kept IDLE; completion occurs on the second cycle.
REQ-025 ErrCount SHALL increment by 1 on each completion with RspError=1 and saturate at 8'hFF.
REQ-026 Minimum command-to-RspValid latency SHALL be 3 cycles with zero wait states (accept, ADDR, DATA); each wait state adds one cycle.
REQ-027 Command acceptance SHALL occur only in IDLE, so RspValid and acceptance of the next command can coincide only from the cycle after completion.
REQ-028 HADDR and HWRITE SHALL retain their last values outside ADDR; HWDATA SHALL retain its last value outside DATA.

Reset
REQ-029 HRESET=1 SHALL immediately force:
  - FSM=IDLE, HTRANS=IDLE, HADDR=0, HWRITE=0, HWDATA=0;
  - RspValid=0, RspError=0, RspRData=0, ErrCount=0;
  - CmdReady=1 after release.
REQ-030 Reset asserted mid-transfer SHALL abandon the transfer without issuing RspValid.

Structure
REQ-031 A shared package ahb_pkg SHALL hold:
  - HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ);
  - HSIZE_WORD, HBURST_SINGLE;
  - HRESP_OKAY/ERROR;
  - the FSM state enumeration.
REQ-032 The block SHALL be a single module with no sub-modules.

Verification
REQ-033 Write 0x0000_1000 / 0xDEAD_BEEF, HREADY=1 throughout -> NONSEQ for one cycle with HWRITE=1, HWDATA=0xDEADBEEF in the following cycle, RspValid 3 cycles after acceptance, RspError=0.
REQ-034 Read 0x0000_2004, slave holds HREADY=0 for 2 data cycles then returns HRDATA=0x1234_5678 -> RspValid on cycle 5, RspRData=0x12345678.
REQ-035 Read to an unmapped address with a two-cycle ERROR -> HTRANS IDLE during both error cycles, RspValid with RspError=1, ErrCount 0->1.
REQ-036 HREADY=0 during ADDR for 3 cycles -> HADDR/HTRANS=NONSEQ held for 4 cycles, CmdReady=0 throughout.
REQ-037 HRESET pulsed during DATA of a write -> all outputs return to reset values at once, no RspValid; a new command is accepted normally afterwards.
REQ-038 257 consecutive ERROR completions -> ErrCount saturates at 0xFF.
